multicycle_control: RTL and testbench

Finite-state controller for the team's multi-cycle MIPS processor. It sequences a shared datapath (one ALU, one unified instruction/data memory, IR, A/B/ALUOut/MDR registers) through fetch, decode, execute, memory and write-back. It supports the same instruction subset as the single-cycle decoder, and adds a memory-ready handshake so slow memory stretches any memory state.

---
 rtl/mc_pkg.sv | 97 +++++++++
 rtl/mc_output_decode.sv | 103 ++++++++++
 rtl/multicycle_control.sv | 94 +++++++++
 tb/tb_multicycle_control.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcode/funct
// values, datapath mux codes and the packed control vector.
package mc_pkg;

    typedef enum logic [3:0] {
        INIT     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        WB_ALU   = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WB   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        JREG     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_SRA  = 6'd3;
    localparam logic [5:0] FN_JR   = 6'd8;
    localparam logic [5:0] FN_JALR = 6'd9;

    localparam logic [1:0] ALUOP_ADD    = 2'd0;
    localparam logic [1:0] ALUOP_SUB    = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT  = 2'd2;
    localparam logic [1:0] ALUOP_OPCODE = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REGA   = 2'd3;

    localparam logic [1:0] SRC1_PC    = 2'd0;
    localparam logic [1:0] SRC1_A     = 2'd1;
    localparam logic [1:0] SRC1_SHAMT = 2'd2;

    localparam logic [1:0] SRC2_B      = 2'd0;
    localparam logic [1:0] SRC2_FOUR   = 2'd1;
    localparam logic [1:0] SRC2_IMM    = 2'd2;
    localparam logic [1:0] SRC2_IMM_SH = 2'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src1;
        logic [1:0] alu_src2;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       lu_op;
        logic       inst_done;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_i_alu(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
               (op == OP_SLTIU) || (op == OP_ANDI) || (op == OP_LUI);
    endfunction

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) ||
               (op == OP_LW) || (op == OP_SW) || is_i_alu(op);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-vector decode from controller state, the current
// instruction fields and the memory-ready handshake.
module mc_output_decode
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read = 1'b1;
                ctrl.alu_src2 = SRC2_FOUR;
                ctrl.ir_write = MemReady;
                ctrl.pc_write = MemReady;
            end
            DECODE: begin
                // Branch target is computed here, so the offset is sign-extended.
                ctrl.alu_src2 = SRC2_IMM_SH;
                ctrl.ext_op   = 1'b1;
                if (OpCode == OP_RTYPE && Funct == FN_JALR) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = DST_RD;
                    ctrl.mem_to_reg = M2R_PC;
                end
                if (!is_known_op(OpCode)) begin
                    ctrl.illegal   = 1'b1;
                    ctrl.inst_done = 1'b1;
                end
            end
            EXEC_R: begin
                ctrl.alu_src1 = (Funct == FN_SLL || Funct == FN_SRL || Funct == FN_SRA)
                              ? SRC1_SHAMT : SRC1_A;
                ctrl.alu_src2 = SRC2_B;
                ctrl.alu_op   = ALUOP_FUNCT;
            end
            EXEC_I: begin
                ctrl.alu_src1 = SRC1_A;
                ctrl.alu_src2 = SRC2_IMM;
                ctrl.alu_op   = ALUOP_OPCODE;
                ctrl.ext_op   = (OpCode != OP_ANDI);
                ctrl.lu_op    = (OpCode == OP_LUI);
            end
            WB_ALU: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = M2R_ALUOUT;
                ctrl.reg_dst    = (OpCode == OP_RTYPE) ? DST_RD : DST_RT;
                ctrl.inst_done  = 1'b1;
            end
            MEM_ADDR: begin
                ctrl.alu_src1 = SRC1_A;
                ctrl.alu_src2 = SRC2_IMM;
                ctrl.alu_op   = ALUOP_ADD;
                ctrl.ext_op   = 1'b1;
            end
            MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = M2R_MDR;
                ctrl.reg_dst    = DST_RT;
                ctrl.inst_done  = 1'b1;
            end
            MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.inst_done = MemReady;
            end
            BRANCH: begin
                ctrl.alu_src1      = SRC1_A;
                ctrl.alu_src2      = SRC2_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
                ctrl.inst_done     = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_src    = PCSRC_JUMP;
                ctrl.inst_done = 1'b1;
                if (OpCode == OP_JAL) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = DST_RA;
                    ctrl.mem_to_reg = M2R_PC;
                end
            end
            JREG: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_src    = PCSRC_REGA;
                ctrl.inst_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: state register and next-state sequencing;
// control outputs come from mc_output_decode.
module multicycle_control
    import mc_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrc1,
    output logic [1:0] ALUSrc2,
    output logic [1:0] ALUOp,
    output logic       ExtOp,
    output logic       LuOp,
    output logic       InstDone,
    output logic       Illegal
);

    state_t state, state_next;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= state_t'(RESET_STATE);
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:  state_next = FETCH;
            FETCH: if (MemReady) state_next = DECODE;
            DECODE: begin
                if (OpCode == OP_RTYPE)
                    state_next = (Funct == FN_JR || Funct == FN_JALR) ? JREG : EXEC_R;
                else if (OpCode == OP_LW || OpCode == OP_SW)
                    state_next = MEM_ADDR;
                else if (is_i_alu(OpCode))
                    state_next = EXEC_I;
                else if (OpCode == OP_BEQ)
                    state_next = BRANCH;
                else if (OpCode == OP_J || OpCode == OP_JAL)
                    state_next = JUMP;
                else
                    state_next = FETCH;
            end
            EXEC_R, EXEC_I: state_next = WB_ALU;
            MEM_ADDR: state_next = (OpCode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (MemReady) state_next = MEM_WB;
            MEM_WR:   if (MemReady) state_next = FETCH;
            WB_ALU, MEM_WB, BRANCH, JUMP, JREG: state_next = FETCH;
            default:  state_next = INIT;
        endcase
    end

    mc_output_decode u_decode (
        .state    (state),
        .OpCode   (OpCode),
        .Funct    (Funct),
        .MemReady (MemReady),
        .ctrl     (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign PCSrc       = ctrl.pc_src;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign ALUSrc1     = ctrl.alu_src1;
    assign ALUSrc2     = ctrl.alu_src2;
    assign ALUOp       = ctrl.alu_op;
    assign ExtOp       = ctrl.ext_op;
    assign LuOp        = ctrl.lu_op;
    assign InstDone    = ctrl.inst_done;
    assign Illegal     = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of instructions with expected latency
// and final-cycle controls, checked through a scoreboard queue.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] PCSrc, RegDst, MemtoReg, ALUSrc1, ALUSrc2, ALUOp;
    logic       ExtOp, LuOp, InstDone, Illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSrc       (PCSrc),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .ALUSrc1     (ALUSrc1),
        .ALUSrc2     (ALUSrc2),
        .ALUOp       (ALUOp),
        .ExtOp       (ExtOp),
        .LuOp        (LuOp),
        .InstDone    (InstDone),
        .Illegal     (Illegal)
    );

    wire [23:0] all_outs = {PCWrite, PCWriteCond, PCSrc, IorD, MemRead, MemWrite, IRWrite,
                            RegWrite, RegDst, MemtoReg, ALUSrc1, ALUSrc2, ALUOp,
                            ExtOp, LuOp, InstDone, Illegal};

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         sf;      // MemReady-low cycles in FETCH
        int         sm;      // MemReady-low cycles in MEM_RD/MEM_WR
        int         lat;     // cycles from first FETCH to InstDone, inclusive
        int         dacc;    // cycles with a data-side memory request
        logic       chk_rw;
        logic       rw;
        logic [1:0] rd, mt;
        logic       pcw, pcwc;
        logic [1:0] pcs;
        logic       mw, ill;
        logic [1:0] c3_op, c3_s1, c3_s2;
    } instr_t;

    instr_t tbl[$];
    instr_t exp_q[$];

    function automatic instr_t mk(input logic [5:0] op, input logic [5:0] funct,
                                  input int sf, input int sm, input int lat, input int dacc,
                                  input logic chk_rw, input logic rw, input logic [1:0] rd,
                                  input logic [1:0] mt, input logic pcw, input logic pcwc,
                                  input logic [1:0] pcs, input logic mw, input logic ill,
                                  input logic [1:0] c3_op, input logic [1:0] c3_s1,
                                  input logic [1:0] c3_s2);
        instr_t r;
        r.op = op; r.funct = funct; r.sf = sf; r.sm = sm; r.lat = lat; r.dacc = dacc;
        r.chk_rw = chk_rw; r.rw = rw; r.rd = rd; r.mt = mt; r.pcw = pcw; r.pcwc = pcwc;
        r.pcs = pcs; r.mw = mw; r.ill = ill; r.c3_op = c3_op; r.c3_s1 = c3_s1; r.c3_s2 = c3_s2;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Called at the falling edge of an instruction's first FETCH cycle; returns
    // at the falling edge of the following instruction's first cycle.
    task automatic run_instr(input instr_t r);
        instr_t e;
        int cyc, dacc, fs, ms;
        bit done;
        exp_q.push_back(r);
        OpCode = r.op;
        Funct  = r.funct;
        fs = r.sf; ms = r.sm; cyc = 0; dacc = 0; done = 0;
        while (!done && cyc < 40) begin
            cyc++;
            if (MemRead || MemWrite) begin
                if (!IorD && fs > 0)     begin MemReady = 1'b0; fs--; end
                else if (IorD && ms > 0) begin MemReady = 1'b0; ms--; end
                else                     MemReady = 1'b1;
            end else begin
                MemReady = 1'($urandom_range(0, 1));
            end
            #1;
            chk("rd_wr_exclusive", {31'd0, MemRead & MemWrite}, 32'd0);
            if (IorD && (MemRead || MemWrite)) dacc++;
            if (cyc == r.sf + 3 && r.lat >= r.sf + 3) begin
                chk("cyc3_aluop", {30'd0, ALUOp},   {30'd0, r.c3_op});
                chk("cyc3_src1",  {30'd0, ALUSrc1}, {30'd0, r.c3_s1});
                chk("cyc3_src2",  {30'd0, ALUSrc2}, {30'd0, r.c3_s2});
            end
            if (InstDone) begin
                done = 1;
                e = exp_q.pop_front();
                chk("latency",   cyc,  e.lat);
                chk("data_cyc",  dacc, e.dacc);
                chk("illegal",   {31'd0, Illegal},     {31'd0, e.ill});
                chk("pcwrite",   {31'd0, PCWrite},     {31'd0, e.pcw});
                chk("pcwcond",   {31'd0, PCWriteCond}, {31'd0, e.pcwc});
                chk("pcsrc",     {30'd0, PCSrc},       {30'd0, e.pcs});
                chk("memwrite",  {31'd0, MemWrite},    {31'd0, e.mw});
                if (e.chk_rw) begin
                    chk("regwrite", {31'd0, RegWrite}, {31'd0, e.rw});
                    chk("regdst",   {30'd0, RegDst},   {30'd0, e.rd});
                    chk("memtoreg", {30'd0, MemtoReg}, {30'd0, e.mt});
                end
            end
            @(negedge clk);
        end
        chk("inst_done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        reset    = 1'b0;
        OpCode   = 6'd0;
        Funct    = 6'd0;
        MemReady = 1'b1;

        //         op   fn  sf sm lat dacc chk rw rd mt pcw pcwc pcs mw ill c3op s1 s2
        tbl.push_back(mk(6'd0,  6'd32, 0, 0, 4, 0, 1, 1, 2'd1, 2'd0, 0, 0, 2'd0, 0, 0, 2'd2, 2'd1, 2'd0));
        tbl.push_back(mk(6'd0,  6'd0,  0, 0, 4, 0, 1, 1, 2'd1, 2'd0, 0, 0, 2'd0, 0, 0, 2'd2, 2'd2, 2'd0));
        tbl.push_back(mk(6'd8,  6'd5,  0, 0, 4, 0, 1, 1, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 2'd3, 2'd1, 2'd2));
        tbl.push_back(mk(6'd12, 6'd0,  0, 0, 4, 0, 1, 1, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 2'd3, 2'd1, 2'd2));
        tbl.push_back(mk(6'd15, 6'd0,  0, 0, 4, 0, 1, 1, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 2'd3, 2'd1, 2'd2));
        tbl.push_back(mk(6'd35, 6'd0,  0, 0, 5, 1, 1, 1, 2'd0, 2'd1, 0, 0, 2'd0, 0, 0, 2'd0, 2'd1, 2'd2));
        tbl.push_back(mk(6'd35, 6'd0,  0, 2, 7, 3, 1, 1, 2'd0, 2'd1, 0, 0, 2'd0, 0, 0, 2'd0, 2'd1, 2'd2));
        tbl.push_back(mk(6'd43, 6'd0,  0, 0, 4, 1, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 1, 0, 2'd0, 2'd1, 2'd2));
        tbl.push_back(mk(6'd43, 6'd0,  1, 1, 6, 2, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 1, 0, 2'd0, 2'd1, 2'd2));
        tbl.push_back(mk(6'd4,  6'd0,  0, 0, 3, 0, 1, 0, 2'd0, 2'd0, 0, 1, 2'd1, 0, 0, 2'd1, 2'd1, 2'd0));
        tbl.push_back(mk(6'd4,  6'd0,  1, 0, 4, 0, 1, 0, 2'd0, 2'd0, 0, 1, 2'd1, 0, 0, 2'd1, 2'd1, 2'd0));
        tbl.push_back(mk(6'd2,  6'd0,  0, 0, 3, 0, 1, 0, 2'd0, 2'd0, 1, 0, 2'd2, 0, 0, 2'd0, 2'd0, 2'd0));
        tbl.push_back(mk(6'd3,  6'd0,  0, 0, 3, 0, 1, 1, 2'd2, 2'd2, 1, 0, 2'd2, 0, 0, 2'd0, 2'd0, 2'd0));
        tbl.push_back(mk(6'd0,  6'd8,  0, 0, 3, 0, 1, 0, 2'd0, 2'd0, 1, 0, 2'd3, 0, 0, 2'd0, 2'd0, 2'd0));
        tbl.push_back(mk(6'd0,  6'd9,  0, 0, 3, 0, 0, 0, 2'd0, 2'd0, 1, 0, 2'd3, 0, 0, 2'd0, 2'd0, 2'd0));
        tbl.push_back(mk(6'd63, 6'd0,  0, 0, 2, 0, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 1, 2'd0, 2'd0, 2'd0));
        tbl.push_back(mk(6'd13, 6'd0,  0, 0, 2, 0, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 1, 2'd0, 2'd0, 2'd0));
        tbl.push_back(mk(6'd0,  6'd32, 2, 0, 6, 0, 1, 1, 2'd1, 2'd0, 0, 0, 2'd0, 0, 0, 2'd2, 2'd1, 2'd0));

        // Reset held low for three cycles: everything quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outs", {8'd0, all_outs}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("first_fetch_memread", {31'd0, MemRead}, 32'd1);
        chk("first_fetch_iord",    {31'd0, IorD},    32'd0);

        // add, cycle by cycle.
        OpCode = 6'd0; Funct = 6'd32; MemReady = 1'b1;
        #1;
        chk("add_c1_irwrite", {31'd0, IRWrite}, 32'd1);
        chk("add_c1_src2",    {30'd0, ALUSrc2}, 32'd1);
        @(negedge clk);
        chk("add_c2_src2",    {30'd0, ALUSrc2}, 32'd3);
        chk("add_c2_irwrite", {31'd0, IRWrite}, 32'd0);
        @(negedge clk);
        chk("add_c3_aluop",   {30'd0, ALUOp},   32'd2);
        chk("add_c3_done",    {31'd0, InstDone}, 32'd0);
        @(negedge clk);
        chk("add_c4_regwrite", {31'd0, RegWrite}, 32'd1);
        chk("add_c4_regdst",   {30'd0, RegDst},   32'd1);
        chk("add_c4_done",     {31'd0, InstDone}, 32'd1);
        @(negedge clk);

        foreach (tbl[i]) run_instr(tbl[i]);

        // sw aborted by reset while stalled in MEM_WR.
        begin
            bit seen = 0;
            OpCode = 6'd43; Funct = 6'd0;
            for (int i = 0; i < 20 && !seen; i++) begin
                MemReady = !(IorD && MemWrite);
                #1;
                if (MemWrite) seen = 1;
                else @(negedge clk);
            end
            chk("mem_wr_reached", {31'd0, seen}, 32'd1);
            #1;
            reset = 1'b0;
            #1;
            chk("abort_memwrite", {31'd0, MemWrite}, 32'd0);
            chk("abort_outs",     {8'd0, all_outs},  32'd0);
            @(negedge clk);
            chk("abort_hold_outs", {8'd0, all_outs}, 32'd0);
            reset = 1'b1;
            MemReady = 1'b1;
            @(negedge clk);
            chk("restart_memread", {31'd0, MemRead}, 32'd1);
            chk("restart_iord",    {31'd0, IorD},    32'd0);
            run_instr(tbl[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
